// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, branch flushes, operand
// forwarding, and a data-memory wait FSM with a sticky timeout error.
// Stall/flush/forward outputs are combinational; the FSM state, timeout
// flag and performance counters are registered.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D_i,
  input  logic [4:0]  Rs2D_i,
  input  logic [4:0]  Rs1E_i,
  input  logic [4:0]  Rs2E_i,
  input  logic [4:0]  RdE_i,
  input  logic [4:0]  RdM_i,
  input  logic [4:0]  RdW_i,
  input  logic        RegWriteM_i,
  input  logic        RegWriteW_i,
  input  logic        ResultSrcE0_i,
  input  logic        PCSrcE_i,
  input  logic        MemReqM_i,
  input  logic        MemReadyM_i,
  output logic        StallF_o,
  output logic        StallD_o,
  output logic        StallE_o,
  output logic        StallM_o,
  output logic        FlushD_o,
  output logic        FlushE_o,
  output logic        FlushW_o,
  output logic [1:0]  ForwardAE_o,
  output logic [1:0]  ForwardBE_o,
  output logic        MemTimeout_o,
  output logic [31:0] StallCount_o,
  output logic [31:0] FlushCount_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_t      r_state;
  logic [7:0]  r_wait_cnt;
  logic        r_timeout;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  logic        w_mem_stall;
  logic        w_lw_stall;

  // Forward select for one source operand; Memory stage beats Writeback.
  function automatic logic [1:0] fwd_sel(
    input logic       regwrite_m,
    input logic [4:0] rd_m,
    input logic       regwrite_w,
    input logic [4:0] rd_w,
    input logic [4:0] rs
  );
    logic [1:0] sel;
    if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Wait counter increment that sticks at its maximum value.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  // Hazard detection terms feeding the stall/flush decode.
  always_comb begin
    w_mem_stall = 1'b0;
    w_lw_stall  = 1'b0;
    case (r_state)
      ST_IDLE:     w_mem_stall = MemReqM_i & ~MemReadyM_i;
      ST_MEM_WAIT: w_mem_stall = 1'b1;
      ST_ERROR:    w_mem_stall = 1'b1;
      default:     w_mem_stall = 1'b1;
    endcase
    w_lw_stall = ResultSrcE0_i && (RdE_i != 5'd0) &&
                 ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
  end

  // Stall, flush and forward outputs; reset forces a pipeline bubble.
  always_comb begin
    StallF_o    = 1'b0;
    StallD_o    = 1'b0;
    StallE_o    = 1'b0;
    StallM_o    = 1'b0;
    FlushD_o    = 1'b0;
    FlushE_o    = 1'b0;
    FlushW_o    = 1'b0;
    ForwardAE_o = 2'b00;
    ForwardBE_o = 2'b00;
    if (rst) begin
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
    end else begin
      ForwardAE_o = fwd_sel(RegWriteM_i, RdM_i, RegWriteW_i, RdW_i, Rs1E_i);
      ForwardBE_o = fwd_sel(RegWriteM_i, RdM_i, RegWriteW_i, RdW_i, Rs2E_i);
      if (w_mem_stall) begin
        // Whole pipe freezes; Writeback gets a bubble, younger flushes wait.
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        StallE_o = 1'b1;
        StallM_o = 1'b1;
        FlushW_o = 1'b1;
      end else begin
        // On lw + branch together, FlushD overrides StallD in the D register.
        StallF_o = w_lw_stall;
        StallD_o = w_lw_stall;
        FlushE_o = w_lw_stall | PCSrcE_i;
        FlushD_o = PCSrcE_i;
      end
    end
  end

  // Memory wait FSM with wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wait_cnt <= 8'd0;
          if (MemReqM_i && !MemReadyM_i) begin
            r_state <= ST_MEM_WAIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_MEM_WAIT: begin
          if (MemReadyM_i) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 8'd0;
          end else if (r_wait_cnt == TIMEOUT_C) begin
            r_state    <= ST_ERROR;
            r_timeout  <= 1'b1;
            r_wait_cnt <= sat_inc(r_wait_cnt);
          end else begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= sat_inc(r_wait_cnt);
          end
        end
        ST_ERROR: begin
          r_state   <= ST_ERROR;
          r_timeout <= 1'b1;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Performance counters for stalled and flushed cycles, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (StallF_o) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (FlushD_o || FlushE_o) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  assign MemTimeout_o = r_timeout;
  assign StallCount_o = r_stall_cnt;
  assign FlushCount_o = r_flush_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller (MEM_TIMEOUT = 4).
module tb_hazard_controller;

  logic        clk;
  logic        rst;
  logic [4:0]  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i;
  logic        RegWriteM_i, RegWriteW_i, ResultSrcE0_i, PCSrcE_i;
  logic        MemReqM_i, MemReadyM_i;
  logic        StallF_o, StallD_o, StallE_o, StallM_o;
  logic        FlushD_o, FlushE_o, FlushW_o;
  logic [1:0]  ForwardAE_o, ForwardBE_o;
  logic        MemTimeout_o;
  logic [31:0] StallCount_o, FlushCount_o;

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  logic [6:0]  ctl;
  assign ctl = {StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o, FlushW_o};

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  hazard_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i),
    .RdE_i(RdE_i), .RdM_i(RdM_i), .RdW_i(RdW_i),
    .RegWriteM_i(RegWriteM_i), .RegWriteW_i(RegWriteW_i),
    .ResultSrcE0_i(ResultSrcE0_i), .PCSrcE_i(PCSrcE_i),
    .MemReqM_i(MemReqM_i), .MemReadyM_i(MemReadyM_i),
    .StallF_o(StallF_o), .StallD_o(StallD_o), .StallE_o(StallE_o), .StallM_o(StallM_o),
    .FlushD_o(FlushD_o), .FlushE_o(FlushE_o), .FlushW_o(FlushW_o),
    .ForwardAE_o(ForwardAE_o), .ForwardBE_o(ForwardBE_o),
    .MemTimeout_o(MemTimeout_o), .StallCount_o(StallCount_o), .FlushCount_o(FlushCount_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs;
    Rs1D_i = 5'd0; Rs2D_i = 5'd0; Rs1E_i = 5'd0; Rs2E_i = 5'd0;
    RdE_i = 5'd0; RdM_i = 5'd0; RdW_i = 5'd0;
    RegWriteM_i = 1'b0; RegWriteW_i = 1'b0; ResultSrcE0_i = 1'b0;
    PCSrcE_i = 1'b0; MemReqM_i = 1'b0; MemReadyM_i = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    MemReqM_i = 1'b1; RegWriteM_i = 1'b1; RdM_i = 5'd3; Rs1E_i = 5'd3;
    step(); step(); settle();
    checks++; if (ctl !== 7'b0000110) begin errors++; $display("FAIL rst_ctl: got %b exp %b", ctl, 7'b0000110); end
    checks++; if (ForwardAE_o !== 2'b00) begin errors++; $display("FAIL rst_fwdA: got %b exp 00", ForwardAE_o); end
    checks++; if (MemTimeout_o !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b exp 0", MemTimeout_o); end
    checks++; if (StallCount_o !== 32'd0 || FlushCount_o !== 32'd0) begin errors++; $display("FAIL rst_counts: got %0d/%0d exp 0/0", StallCount_o, FlushCount_o); end
    rst = 1'b0;
    clear_inputs();
    settle();
    checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL idle_ctl: got %b exp %b", ctl, 7'b0000000); end
    step();
    checks++; if (StallCount_o !== 32'd0 || FlushCount_o !== 32'd0) begin errors++; $display("FAIL idle_counts: got %0d/%0d exp 0/0", StallCount_o, FlushCount_o); end
  endtask

  task automatic test_load_use;
    clear_inputs();
    ResultSrcE0_i = 1'b1; RdE_i = 5'd5; Rs1D_i = 5'd5;
    settle();
    checks++; if (ctl !== 7'b1100010) begin errors++; $display("FAIL lu_rs1_ctl: got %b exp %b", ctl, 7'b1100010); end
    step(); exp_stall += 1; exp_flush += 1;
    checks++; if (StallCount_o !== 32'(exp_stall) || FlushCount_o !== 32'(exp_flush)) begin errors++; $display("FAIL lu_rs1_counts: got %0d/%0d exp %0d/%0d", StallCount_o, FlushCount_o, exp_stall, exp_flush); end
    clear_inputs();
    ResultSrcE0_i = 1'b1; RdE_i = 5'd7; Rs2D_i = 5'd7; Rs1D_i = 5'd1;
    settle();
    checks++; if (ctl !== 7'b1100010) begin errors++; $display("FAIL lu_rs2_ctl: got %b exp %b", ctl, 7'b1100010); end
    step(); exp_stall += 1; exp_flush += 1;
    checks++; if (StallCount_o !== 32'(exp_stall) || FlushCount_o !== 32'(exp_flush)) begin errors++; $display("FAIL lu_rs2_counts: got %0d/%0d exp %0d/%0d", StallCount_o, FlushCount_o, exp_stall, exp_flush); end
  endtask

  task automatic test_rde_zero;
    clear_inputs();
    ResultSrcE0_i = 1'b1; RdE_i = 5'd0; Rs2D_i = 5'd0; Rs1D_i = 5'd0;
    settle();
    checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL rd0_ctl: got %b exp %b", ctl, 7'b0000000); end
    ResultSrcE0_i = 1'b0; RdE_i = 5'd5; Rs1D_i = 5'd5;
    settle();
    checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL noload_ctl: got %b exp %b", ctl, 7'b0000000); end
    step();
    checks++; if (StallCount_o !== 32'(exp_stall) || FlushCount_o !== 32'(exp_flush)) begin errors++; $display("FAIL rd0_counts: got %0d/%0d exp %0d/%0d", StallCount_o, FlushCount_o, exp_stall, exp_flush); end
  endtask

  task automatic test_forwarding;
    clear_inputs();
    RegWriteM_i = 1'b1; RdM_i = 5'd3; RegWriteW_i = 1'b1; RdW_i = 5'd3; Rs1E_i = 5'd3; Rs2E_i = 5'd0;
    settle();
    checks++; if (ForwardAE_o !== 2'b10) begin errors++; $display("FAIL fwdA_mem: got %b exp 10", ForwardAE_o); end
    checks++; if (ForwardBE_o !== 2'b00) begin errors++; $display("FAIL fwdB_none: got %b exp 00", ForwardBE_o); end
    RegWriteM_i = 1'b0;
    settle();
    checks++; if (ForwardAE_o !== 2'b01) begin errors++; $display("FAIL fwdA_wb: got %b exp 01", ForwardAE_o); end
    RegWriteM_i = 1'b1; RdM_i = 5'd0; RdW_i = 5'd0; Rs1E_i = 5'd0;
    settle();
    checks++; if (ForwardAE_o !== 2'b00) begin errors++; $display("FAIL fwdA_x0: got %b exp 00", ForwardAE_o); end
    RdM_i = 5'd9; RdW_i = 5'd9; Rs2E_i = 5'd9;
    settle();
    checks++; if (ForwardBE_o !== 2'b10) begin errors++; $display("FAIL fwdB_mem: got %b exp 10", ForwardBE_o); end
    RdM_i = 5'd4;
    settle();
    checks++; if (ForwardBE_o !== 2'b01) begin errors++; $display("FAIL fwdB_wb: got %b exp 01", ForwardBE_o); end
    checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL fwd_ctl: got %b exp %b", ctl, 7'b0000000); end
    step();
  endtask

  task automatic test_branch;
    clear_inputs();
    PCSrcE_i = 1'b1;
    settle();
    checks++; if (ctl !== 7'b0000110) begin errors++; $display("FAIL br_ctl: got %b exp %b", ctl, 7'b0000110); end
    step(); exp_flush += 1;
    ResultSrcE0_i = 1'b1; RdE_i = 5'd5; Rs1D_i = 5'd5;
    settle();
    checks++; if (ctl !== 7'b1100110) begin errors++; $display("FAIL lwbr_ctl: got %b exp %b", ctl, 7'b1100110); end
    step(); exp_stall += 1; exp_flush += 1;
    checks++; if (StallCount_o !== 32'(exp_stall) || FlushCount_o !== 32'(exp_flush)) begin errors++; $display("FAIL br_counts: got %0d/%0d exp %0d/%0d", StallCount_o, FlushCount_o, exp_stall, exp_flush); end
  endtask

  task automatic test_mem_wait;
    clear_inputs();
    MemReqM_i = 1'b1; MemReadyM_i = 1'b0;
    ResultSrcE0_i = 1'b1; RdE_i = 5'd5; Rs1D_i = 5'd5;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (ctl !== 7'b1111001) begin errors++; $display("FAIL mw_ctl[%0d]: got %b exp %b", i, ctl, 7'b1111001); end
      step(); exp_stall += 1;
    end
    MemReadyM_i = 1'b1;
    settle();
    checks++; if (ctl !== 7'b1111001) begin errors++; $display("FAIL mw_ready_ctl: got %b exp %b", ctl, 7'b1111001); end
    step(); exp_stall += 1;
    clear_inputs();
    settle();
    checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL mw_idle_ctl: got %b exp %b", ctl, 7'b0000000); end
    checks++; if (StallCount_o !== 32'(exp_stall) || FlushCount_o !== 32'(exp_flush)) begin errors++; $display("FAIL mw_counts: got %0d/%0d exp %0d/%0d", StallCount_o, FlushCount_o, exp_stall, exp_flush); end
    step();
  endtask

  task automatic test_branch_in_wait;
    clear_inputs();
    MemReqM_i = 1'b1; PCSrcE_i = 1'b1;
    settle();
    checks++; if (ctl !== 7'b1111001) begin errors++; $display("FAIL bw_idle_ctl: got %b exp %b", ctl, 7'b1111001); end
    step(); exp_stall += 1;
    settle();
    checks++; if (ctl !== 7'b1111001) begin errors++; $display("FAIL bw_wait_ctl: got %b exp %b", ctl, 7'b1111001); end
    step(); exp_stall += 1;
    MemReadyM_i = 1'b1;
    settle();
    checks++; if (ctl !== 7'b1111001) begin errors++; $display("FAIL bw_ready_ctl: got %b exp %b", ctl, 7'b1111001); end
    step(); exp_stall += 1;
    settle();
    checks++; if (ctl !== 7'b0000110) begin errors++; $display("FAIL bw_after_ctl: got %b exp %b", ctl, 7'b0000110); end
    step(); exp_flush += 1;
    checks++; if (StallCount_o !== 32'(exp_stall) || FlushCount_o !== 32'(exp_flush)) begin errors++; $display("FAIL bw_counts: got %0d/%0d exp %0d/%0d", StallCount_o, FlushCount_o, exp_stall, exp_flush); end
    clear_inputs();
  endtask

  task automatic test_timeout;
    clear_inputs();
    MemReqM_i = 1'b1; MemReadyM_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      settle();
      checks++; if (ctl !== 7'b1111001 || MemTimeout_o !== 1'b0) begin errors++; $display("FAIL to_wait[%0d]: got ctl %b to %b exp %b to 0", i, ctl, MemTimeout_o, 7'b1111001); end
      step(); exp_stall += 1;
    end
    settle();
    checks++; if (MemTimeout_o !== 1'b1) begin errors++; $display("FAIL to_set: got %b exp 1", MemTimeout_o); end
    MemReqM_i = 1'b0;
    settle();
    checks++; if (ctl !== 7'b1111001) begin errors++; $display("FAIL to_err_ctl: got %b exp %b", ctl, 7'b1111001); end
    step(); exp_stall += 1;
    MemReadyM_i = 1'b1;
    settle();
    checks++; if (ctl !== 7'b1111001 || MemTimeout_o !== 1'b1) begin errors++; $display("FAIL to_sticky: got ctl %b to %b exp %b to 1", ctl, MemTimeout_o, 7'b1111001); end
    step(); exp_stall += 1;
    checks++; if (StallCount_o !== 32'(exp_stall)) begin errors++; $display("FAIL to_stallcnt: got %0d exp %0d", StallCount_o, exp_stall); end
    rst = 1'b1;
    settle();
    checks++; if (ctl !== 7'b0000110) begin errors++; $display("FAIL to_rst_ctl: got %b exp %b", ctl, 7'b0000110); end
    step();
    exp_stall = 0; exp_flush = 0;
    checks++; if (MemTimeout_o !== 1'b0 || StallCount_o !== 32'd0 || FlushCount_o !== 32'd0) begin errors++; $display("FAIL to_rst_regs: got to %b counts %0d/%0d exp 0 0/0", MemTimeout_o, StallCount_o, FlushCount_o); end
    rst = 1'b0;
    clear_inputs();
    settle();
    checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL to_post_ctl: got %b exp %b", ctl, 7'b0000000); end
    step();
    checks++; if (StallCount_o !== 32'd0 || MemTimeout_o !== 1'b0) begin errors++; $display("FAIL to_post_regs: got cnt %0d to %b exp 0 0", StallCount_o, MemTimeout_o); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_rde_zero();
    test_forwarding();
    test_branch();
    test_mem_wait();
    test_branch_in_wait();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
